// File: rtl/des_pkg.sv
// DES constant tables and bit-permutation helpers shared by the round and the core.
// Table entries use DES numbering: bit 1 is the MSB of each vector.
package des_pkg;

    localparam int BLK_W      = 64;
    localparam int HALF_W     = 32;
    localparam int SUBKEY_W   = 48;
    localparam int KEY_HALF_W = 28;
    localparam int ROUNDS     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28,  15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2,  41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56,  34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box: 4 rows of 16, indexed by {row, col}.
    localparam int S_T [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-IP_T[k]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-FP_T[k]];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y[47-k] = x[32-E_T[k]];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) y[31-k] = x[32-P_T[k]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y[47-k] = x[56-PC2_T[k]];
        return y;
    endfunction

    // Eight 6->4 lookups; row is the outer bit pair, column the inner four bits.
    function automatic logic [31:0] sbox(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        int          idx;
        y = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = {26'd0, six[5], six[0], six[4:1]};
            y[31-4*b -: 4] = 4'(S_T[b][idx]);
        end
        return y;
    endfunction

    // Total left rotation of C/D reached after rounds 0..idx.
    function automatic logic [4:0] cum_shift(input logic [3:0] idx);
        int sum;
        sum = 0;
        for (int j = 0; j < 16; j++) if (j <= int'(idx)) sum += SHIFT_T[j];
        return 5'(sum);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] amt);
        logic [55:0] t;
        t = {x, x} << amt;
        return t[55:28];
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   l_i,
    input  logic [HALF_W-1:0]   r_i,
    input  logic [SUBKEY_W-1:0] subkey_i,
    output logic [HALF_W-1:0]   l_o,
    output logic [HALF_W-1:0]   r_o
);

    assign l_o = r_i;
    assign r_o = l_i ^ perm_p(sbox(perm_e(r_i) ^ subkey_i));

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: RPC rounds per clock, one block in flight, valid/ready on both sides.
module des_iter_core
    import des_pkg::*;
#(
    parameter int RPC   = 1,
    parameter int KEY_W = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic [KEY_W-1:0] in_key,
    input  logic             in_decrypt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("des_iter_core: RPC must be 1, 2, 4, 8 or 16");
    end
    if (KEY_W != 56) begin : g_bad_key
        $error("des_iter_core: KEY_W must be 56");
    end

    localparam logic [4:0] RPC_STEP = 5'(RPC);

    state_e                  state_q;
    logic [4:0]              rnd_q;
    logic [HALF_W-1:0]       l_q, r_q;
    logic [KEY_HALF_W-1:0]   c_q, d_q;
    logic                    dec_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [BLK_W-1:0]        out_data_q;

    // C/D hold the loaded key for the whole block; each round rotates a copy by
    // the cumulative schedule amount, so the registers are back at C0/D0 by
    // construction. Decrypt round i uses K(16-i), i.e. the encrypt amount of round 15-i.
    function automatic logic [SUBKEY_W-1:0] subkey_f(input logic [KEY_HALF_W-1:0] c,
                                                     input logic [KEY_HALF_W-1:0] d,
                                                     input logic [3:0]            idx,
                                                     input logic                  dec);
        logic [4:0] amt;
        amt = dec ? cum_shift(4'd15 - idx) : cum_shift(idx);
        return perm_pc2({rotl28(c, amt), rotl28(d, amt)});
    endfunction

    logic [RPC:0][HALF_W-1:0]     l_ch, r_ch;
    logic [RPC-1:0][SUBKEY_W-1:0] k_ch;

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        assign k_ch[j] = subkey_f(c_q, d_q, rnd_q[3:0] + 4'(j), dec_q);

        des_round u_round (
            .l_i      (l_ch[j]),
            .r_i      (r_ch[j]),
            .subkey_i (k_ch[j]),
            .l_o      (l_ch[j+1]),
            .r_o      (r_ch[j+1])
        );
    end

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            dec_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        {l_q, r_q} <= perm_ip(in_data);
                        {c_q, d_q} <= in_key;
                        dec_q      <= in_decrypt;
                        rnd_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_q   <= l_ch[RPC];
                    r_q   <= r_ch[RPC];
                    rnd_q <= rnd_q + RPC_STEP;
                    if (rnd_q + RPC_STEP == 5'd16) begin
                        // Halves swapped back before FP: no swap after the last round.
                        out_data_q  <= perm_fp({r_ch[RPC], l_ch[RPC]});
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        rnd_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench for des_iter_core; five instances (RPC 1..16) share all inputs.
module tb_des_iter_core;

    localparam logic [55:0] KEY_F = 56'hF0CCAAF556678F;
    localparam logic [63:0] PT_F  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_F  = 64'h85E813540F0AB405;
    localparam logic [63:0] CT_0  = 64'h8CA64DE9C1B123A7;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [63:0]      in_data;
    logic [55:0]      in_key;
    logic             in_decrypt;
    logic             out_ready;
    logic [4:0]       rdy, vld;
    logic [4:0][63:0] odat;

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_iter_core #(.RPC(1 << g), .KEY_W(56)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (rdy[g]),
            .in_data    (in_data),
            .in_key     (in_key),
            .in_decrypt (in_decrypt),
            .out_valid  (vld[g]),
            .out_ready  (out_ready),
            .out_data   (odat[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one block; returns at the negedge after the acceptance edge.
    task automatic offer(input logic [63:0] d, input logic [55:0] k, input logic dec);
        @(negedge clk);
        check("in_ready_before_accept", 64'(rdy[0]), 64'd1);
        in_valid = 1'b1; in_data = d; in_key = k; in_decrypt = dec;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Cycles from acceptance until the RPC=1 instance shows out_valid (bounded).
    task automatic wait_u1(output int lat, input bit scramble);
        lat = 0;
        while (!vld[0] && lat < 40) begin
            if (scramble) begin
                in_data    = {$urandom(), $urandom()};
                in_key     = 56'({$urandom(), $urandom()});
                in_decrypt = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int first [5];
        logic [63:0] cap [5];

        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0;
        in_decrypt = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", 64'(rdy[0]), 64'd0);
        check("reset_out_valid", 64'(vld[0]), 64'd0);
        check("reset_out_data", odat[0], 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(rdy[0]), 64'd1);

        // FIPS encrypt, RPC=1 latency
        offer(PT_F, KEY_F, 1'b0);
        wait_u1(lat, 1'b0);
        check("enc_latency", 64'(lat), 64'd16);
        check("enc_data", odat[0], CT_F);
        @(negedge clk);
        check("enc_hs_valid_low", 64'(vld[0]), 64'd0);
        check("enc_hs_ready_high", 64'(rdy[0]), 64'd1);

        // Decrypt round trip
        offer(CT_F, KEY_F, 1'b1);
        wait_u1(lat, 1'b0);
        check("dec_latency", 64'(lat), 64'd16);
        check("dec_data", odat[0], PT_F);

        // Zero key / zero block across all RPC values
        offer(64'd0, 56'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin first[i] = -1; cap[i] = '0; end
        for (int c = 0; c < 21; c++) begin
            for (int i = 0; i < 5; i++)
                if (vld[i] && first[i] < 0) begin first[i] = c; cap[i] = odat[i]; end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sweep_latency_rpc%0d", 1 << i), 64'(first[i]), 64'(16 >> i));
            check($sformatf("sweep_data_rpc%0d", 1 << i), cap[i], CT_0);
        end

        // Backpressure: hold DONE for 20 cycles
        out_ready = 1'b0;
        offer(PT_F, KEY_F, 1'b0);
        wait_u1(lat, 1'b0);
        check("bp_latency", 64'(lat), 64'd16);
        for (int c = 0; c < 20; c++) begin
            check("bp_data_stable", odat[0], CT_F);
            check("bp_valid_ready", 64'({vld[0], rdy[0]}), 64'b10);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(vld[0]), 64'd0);
        check("bp_release_ready", 64'(rdy[0]), 64'd1);

        // Input isolation during RUN
        offer(PT_F, KEY_F, 1'b0);
        wait_u1(lat, 1'b1);
        check("iso_latency", 64'(lat), 64'd16);
        check("iso_data", odat[0], CT_F);
        in_data = '0; in_key = '0; in_decrypt = 1'b0;
        @(negedge clk);

        // Reset while RPC=1 is at round 7 and RPC=16 is stalled in DONE
        out_ready = 1'b0;
        offer(PT_F, KEY_F, 1'b0);
        repeat (7) @(negedge clk);
        check("pre_reset_rpc16_valid", 64'(vld[4]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(vld[0]), 64'd0);
        check("midrst_out_data", odat[0], 64'd0);
        check("midrst_in_ready", 64'(rdy[0]), 64'd0);
        check("midrst_rpc16_valid", 64'(vld[4]), 64'd0);
        check("midrst_rpc16_data", odat[4], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(CT_F, KEY_F, 1'b1);
        wait_u1(lat, 1'b0);
        check("post_rst_latency", 64'(lat), 64'd16);
        check("post_rst_data", odat[0], PT_F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
- Iterative, clocked DES engine. Successor to the fully combinational 16-round encrypt datapath.
- Adds encrypt/decrypt mode, a parametrised number of rounds per clock (area/throughput trade), and valid/ready handshakes on both sides.
- Sits between the block-cipher front-end (mode/IV logic) and the output buffer; one 64-bit block in flight at a time.

Parameters:
- RPC, default 1: rounds per clock. Legal values 1, 2, 4, 8, 16; any other value is an elaboration error. Latency N = 16/RPC cycles.
- KEY_W, default 56: key width. Fixed at 56; exposed for package checks only.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: block and key offered.
- in_ready, output, 1: core can accept.
- in_data, input, 64: plaintext (encrypt) or ciphertext (decrypt). Bit 63 is DES bit 1.
- in_key, input, 56: key already in PC-1 order, {C0[27:0], D0[27:0]}.
- in_decrypt, input, 1: 0 = encrypt, 1 = decrypt. Sampled with the block.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts.
- out_data, output, 64: result after FP.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while in reset, out_valid=0, out_data=0, round counter=0, L/R/C/D/mode registers=0. Deassertion is synchronised by the surrounding reset tree.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1. On in_valid & in_ready: latch {L,R}=IP(in_data), {C,D}=in_key, mode=in_decrypt, rnd=0, go to RUN.
  - Inputs are ignored when in_valid=0.
- RUN:
  - in_ready=0. Each clock applies RPC consecutive rounds combinationally and advances rnd by RPC.
  - Encrypt round i (0-based): rotate C,D left by SHIFT[i] before PC-2.
  - Decrypt round i: subkey = PC-2 of C,D first rotated right by SHIFT[16-i] for i>=1, with no rotation at i=0. This yields K16..K1 exactly. C,D return to the loaded value after 16 rounds in both modes.
  - Round: L'=R, R'=L ^ P(S(E(R) ^ K)).
  - On the clock where rnd+RPC == 16: out_data <= FP({R16,L16}) (swap, no final-round swap), out_valid <= 1, go to DONE.
- Latency: acceptance edge E -> out_valid first high after edge E+N (N=16 for RPC=1, 1 for RPC=16).
- DONE:
  - out_valid=1 and out_data held stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, go to IDLE. in_ready rises the following cycle (no same-cycle reaccept).
  - out_ready has no effect outside DONE.
- Backpressure: out_ready=0 holds DONE indefinitely with no data change.
- Changes on in_data, in_key, or in_decrypt during RUN or DONE have no effect.
- Reset mid-RUN or mid-DONE: block discarded, out_valid drops asynchronously, state=IDLE.
- Throughput: one block per N+2 cycles with out_ready held high.
- Round counter width: 5 bits. Never exceeds 16.

Decomposition:
- des_pkg holds:
  - IP, FP, E, P, and PC-2 index tables.
  - S-box tables S1..S8.
  - SHIFT[0:15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Localparams BLK_W=64, HALF_W=32, SUBKEY_W=48.
- Sub-module des_round: purely combinational single round, (l, r, subkey) -> (l_n, r_n). The core instantiates RPC copies in a generate chain with a per-copy subkey mux driven by rnd and mode.
- Subkey derivation and the state machine stay in des_iter_core.

Test Plan:
- Encrypt FIPS vector: RPC=1, in_key=0xF0CCAAF556678F, in_data=0x0123456789ABCDEF, in_decrypt=0 -> out_data=0x85E813540F0AB405, out_valid rising exactly 16 cycles after acceptance.
- Decrypt round-trip: same key, in_data=0x85E813540F0AB405, in_decrypt=1 -> out_data=0x0123456789ABCDEF.
- Parameter sweep: RPC in {1,2,4,8,16}, in_key=0, in_data=0 -> out_data=0x8CA64DE9C1B123A7 with latency 16, 8, 4, 2, 1 cycles respectively.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 throughout; release -> handshake completes, in_ready=1 next cycle.
- Input isolation: toggle in_data, in_key, and in_decrypt randomly during RUN -> result still 0x85E813540F0AB405.
- Reset mid-operation: assert rst_n=0 at round 7 -> out_valid=0 and out_data=0 immediately. After release, a fresh vector completes correctly.
